// File: rtl/apu_cluster_arbiter.sv
// rtl/apu_cluster_arbiter.sv - round-robin sharing of one APU among cv32e40p cores
// Requests are held until granted; a tag FIFO returns in-order results to the issuing core.
module apu_cluster_arbiter #(
  parameter int NUM_CORES    = 4,
  parameter int DEPTH        = 2,
  parameter int APU_NARGS    = 3,
  parameter int APU_WOP      = 6,
  parameter int WAPUTYPE     = 6,
  parameter int APU_NDSFLAGS = 15,
  parameter int APU_NUSFLAGS = 5
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_CORES-1:0]              core_req_i,
  output logic [NUM_CORES-1:0]              core_gnt_o,
  input  logic [NUM_CORES*APU_NARGS*32-1:0] core_operands_i,
  input  logic [NUM_CORES*APU_WOP-1:0]      core_op_i,
  input  logic [NUM_CORES*WAPUTYPE-1:0]     core_type_i,
  input  logic [NUM_CORES*APU_NDSFLAGS-1:0] core_flags_i,
  output logic [NUM_CORES-1:0]              core_valid_o,
  output logic [31:0]                       core_result_o,
  output logic [APU_NUSFLAGS-1:0]           core_flags_o,
  output logic                              apu_req_o,
  input  logic                              apu_gnt_i,
  output logic [APU_NARGS*32-1:0]           apu_operands_o,
  output logic [APU_WOP-1:0]                apu_op_o,
  output logic [WAPUTYPE-1:0]               apu_type_o,
  output logic [APU_NDSFLAGS-1:0]           apu_flags_o,
  input  logic                              apu_valid_i,
  input  logic [31:0]                       apu_result_i,
  input  logic [APU_NUSFLAGS-1:0]           apu_flags_i,
  output logic                              err_o
);

  localparam int RW = $clog2(NUM_CORES);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = APU_NARGS * 32;

  typedef enum logic {FREE, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] rr_q, rr_d, sel_q, sel_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [RW-1:0] tag_q [DEPTH];

  logic [RW-1:0] rr_win, winner, mux_sel;
  logic          rr_found, not_full, grant, pop;
  int            cand;

  logic [OW-1:0]           ops_a   [NUM_CORES];
  logic [APU_WOP-1:0]      op_a    [NUM_CORES];
  logic [WAPUTYPE-1:0]     type_a  [NUM_CORES];
  logic [APU_NDSFLAGS-1:0] flags_a [NUM_CORES];

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_unpack
    assign ops_a[k]   = core_operands_i[k*OW +: OW];
    assign op_a[k]    = core_op_i[k*APU_WOP +: APU_WOP];
    assign type_a[k]  = core_type_i[k*WAPUTYPE +: WAPUTYPE];
    assign flags_a[k] = core_flags_i[k*APU_NDSFLAGS +: APU_NDSFLAGS];
  end

  // First requester at or after the rr pointer, wrapping at NUM_CORES.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    cand     = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!rr_found && core_req_i[RW'(cand)]) begin
        rr_found = 1'b1;
        rr_win   = RW'(cand);
      end
    end
  end

  assign winner    = (state_q == LOCKED) ? sel_q : rr_win;
  assign not_full  = (count_q < CW'(DEPTH));
  assign apu_req_o = core_req_i[winner] && not_full;
  assign grant     = apu_req_o && apu_gnt_i;
  assign pop       = apu_valid_i && (count_q != '0);
  assign mux_sel   = apu_req_o ? winner : '0;

  assign apu_operands_o = ops_a[mux_sel];
  assign apu_op_o       = op_a[mux_sel];
  assign apu_type_o     = type_a[mux_sel];
  assign apu_flags_o    = flags_a[mux_sel];
  assign core_result_o  = apu_result_i;
  assign core_flags_o   = apu_flags_i;
  assign err_o          = err_q;

  always_comb begin
    core_gnt_o   = '0;
    core_valid_o = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      core_gnt_o[k]   = grant && (winner == RW'(k));
      core_valid_o[k] = pop && (tag_q[rd_ptr_q] == RW'(k));
    end
  end

  // While the FIFO is full the selection is frozen, even if the requester drops.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    if (grant) begin
      state_d = FREE;
      rr_d    = (winner == RW'(NUM_CORES - 1)) ? '0 : winner + RW'(1);
    end else if (not_full) begin
      if (state_q == FREE && apu_req_o) begin
        state_d = LOCKED;
        sel_d   = winner;
      end else if (state_q == LOCKED && !core_req_i[sel_q]) begin
        state_d = FREE;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (grant) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)   rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    case ({grant, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    err_d = err_q | (apu_valid_i && (count_q == '0));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= FREE;
      rr_q     <= '0;
      sel_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      sel_q    <= sel_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read while count_q is non-zero.
  always_ff @(posedge clk_i) begin
    if (grant) tag_q[wr_ptr_q] <= winner;
  end

endmodule

// File: tb/tb_apu_cluster_arbiter.sv
// tb/tb_apu_cluster_arbiter.sv - randomized bench for apu_cluster_arbiter against a queue-based model
module tb_apu_cluster_arbiter;
  localparam int N     = 4;
  localparam int DEPTH = 2;
  localparam int NARGS = 3;
  localparam int WOP   = 6;
  localparam int WTYP  = 6;
  localparam int NDS   = 15;
  localparam int NUS   = 5;
  localparam int OW    = NARGS * 32;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b0;
  logic [N-1:0]       core_req_i = '0;
  logic [N-1:0]       core_gnt_o;
  logic [N*OW-1:0]    core_operands_i = '0;
  logic [N*WOP-1:0]   core_op_i = '0;
  logic [N*WTYP-1:0]  core_type_i = '0;
  logic [N*NDS-1:0]   core_flags_i = '0;
  logic [N-1:0]       core_valid_o;
  logic [31:0]        core_result_o;
  logic [NUS-1:0]     core_flags_o;
  logic               apu_req_o;
  logic               apu_gnt_i = 1'b0;
  logic [OW-1:0]      apu_operands_o;
  logic [WOP-1:0]     apu_op_o;
  logic [WTYP-1:0]    apu_type_o;
  logic [NDS-1:0]     apu_flags_o;
  logic               apu_valid_i = 1'b0;
  logic [31:0]        apu_result_i = '0;
  logic [NUS-1:0]     apu_flags_i = '0;
  logic               err_o;

  apu_cluster_arbiter #(
    .NUM_CORES(N), .DEPTH(DEPTH), .APU_NARGS(NARGS), .APU_WOP(WOP),
    .WAPUTYPE(WTYP), .APU_NDSFLAGS(NDS), .APU_NUSFLAGS(NUS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_operands_i(core_operands_i), .core_op_i(core_op_i),
    .core_type_i(core_type_i), .core_flags_i(core_flags_i),
    .core_valid_o(core_valid_o), .core_result_o(core_result_o), .core_flags_o(core_flags_o),
    .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
    .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o),
    .apu_type_o(apu_type_o), .apu_flags_o(apu_flags_o),
    .apu_valid_i(apu_valid_i), .apu_result_i(apu_result_i), .apu_flags_i(apu_flags_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Model: outstanding issuers in order, rr start point, held core (-1 when none), sticky error.
  int     m_q[$], n_q[$];
  int     m_rr, n_rr, m_hold, n_hold;
  bit     m_err, n_err_flag;
  logic [N-1:0] last_gnt;
  logic [N-1:0] req_v;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] ops_of(input int k);
    return core_operands_i[k*OW +: OW];
  endfunction

  task automatic set_in(input logic [N-1:0] req, input bit gnt, input bit vld);
    core_req_i  = req;
    apu_gnt_i   = gnt;
    apu_valid_i = vld;
    for (int w = 0; w < N*OW/32; w++) core_operands_i[w*32 +: 32] = $urandom;
    for (int c = 0; c < N; c++) begin
      core_op_i[c*WOP +: WOP]     = WOP'($urandom);
      core_type_i[c*WTYP +: WTYP] = WTYP'($urandom);
      core_flags_i[c*NDS +: NDS]  = NDS'($urandom);
    end
    apu_result_i = $urandom;
    apu_flags_i  = NUS'($urandom);
  endtask

  task automatic settle_check();
    int win, c;
    bit found, er;
    logic [N-1:0] eg, ev;
    #1;
    found = 0;
    win   = 0;
    if (m_hold >= 0) begin
      win = m_hold;
      found = 1;
    end else begin
      for (int i = 0; i < N; i++) begin
        c = (m_rr + i) % N;
        if (!found && core_req_i[c]) begin
          found = 1;
          win = c;
        end
      end
    end
    er = found && core_req_i[win] && (m_q.size() < DEPTH);
    eg = '0;
    if (er && apu_gnt_i) eg[win] = 1'b1;
    ev = '0;
    if (apu_valid_i && m_q.size() > 0) ev[m_q[0]] = 1'b1;
    check("apu_req", apu_req_o, er);
    check("core_gnt", core_gnt_o, eg);
    check("core_valid", core_valid_o, ev);
    check("err", err_o, m_err);
    check("result", core_result_o, apu_result_i);
    check("us_flags", core_flags_o, apu_flags_i);
    if (er) begin
      check("operands", apu_operands_o, ops_of(win));
      check("op", apu_op_o, core_op_i[win*WOP +: WOP]);
      check("type", apu_type_o, core_type_i[win*WTYP +: WTYP]);
      check("ds_flags", apu_flags_o, core_flags_i[win*NDS +: NDS]);
    end
    n_q        = m_q;
    n_rr       = m_rr;
    n_hold     = m_hold;
    n_err_flag = m_err || (apu_valid_i && m_q.size() == 0);
    if (apu_valid_i && n_q.size() > 0) void'(n_q.pop_front());
    if (eg != '0) begin
      n_q.push_back(win);
      n_rr   = (win + 1) % N;
      n_hold = -1;
    end else if (m_q.size() < DEPTH) begin
      if (m_hold < 0 && er) n_hold = win;
      else if (m_hold >= 0 && !core_req_i[m_hold]) n_hold = -1;
    end
    last_gnt = eg;
  endtask

  task automatic commit();
    @(posedge clk_i);
    m_q    = n_q;
    m_rr   = n_rr;
    m_hold = n_hold;
    m_err  = n_err_flag;
    #2;
  endtask

  task automatic cyc(input logic [N-1:0] req, input bit gnt, input bit vld);
    set_in(req, gnt, vld);
    settle_check();
    commit();
  endtask

  task automatic do_reset();
    set_in('0, 0, 0);
    rst_i = 1'b1;
    m_q.delete();
    m_rr   = 0;
    m_hold = -1;
    m_err  = 0;
    #1;
    check("rst_gnt", core_gnt_o, '0);
    check("rst_valid", core_valid_o, '0);
    check("rst_req", apu_req_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < 8 && m_q.size() > 0; g++) cyc('0, 0, 1);
    check("drained", m_q.size(), 0);
  endtask

  logic [N-1:0] rr_exp [5];

  initial begin
    do_reset();

    // Single core with fixed opcode and result.
    set_in(4'b0100, 1, 0);
    core_op_i[2*WOP +: WOP] = 6'h05;
    settle_check();
    check("t1_gnt", core_gnt_o, 4'b0100);
    check("t1_op", apu_op_o, 6'h05);
    commit();
    cyc('0, 0, 0);
    cyc('0, 0, 0);
    set_in('0, 0, 1);
    apu_result_i = 32'hDEADBEEF;
    settle_check();
    check("t1_valid", core_valid_o, 4'b0100);
    check("t1_result", core_result_o, 32'hDEADBEEF);
    commit();

    // Round robin over cores 0, 1, 3.
    do_reset();
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b1000;
    rr_exp[3] = 4'b0001; rr_exp[4] = 4'b0010;
    for (int s = 0; s < 5; s++) begin
      set_in(4'b1011, 1, s != 0);
      settle_check();
      check("rr_gnt", core_gnt_o, rr_exp[s]);
      commit();
    end
    drain();

    // Lock under backpressure.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      set_in(s < 3 ? 4'b0010 : 4'b0011, 0, 0);
      settle_check();
      check("lock_ops", apu_operands_o, ops_of(1));
      commit();
    end
    set_in(4'b0011, 1, 0);
    settle_check();
    check("lock_gnt1", core_gnt_o, 4'b0010);
    commit();
    set_in(4'b0001, 1, 0);
    settle_check();
    check("lock_gnt0", core_gnt_o, 4'b0001);
    commit();
    drain();

    // FIFO full.
    do_reset();
    cyc(4'b0001, 1, 0);
    cyc(4'b0010, 1, 0);
    set_in(4'b0100, 1, 0);
    settle_check();
    check("full_req", apu_req_o, 1'b0);
    commit();
    set_in(4'b0100, 1, 1);
    settle_check();
    check("full_pop_req", apu_req_o, 1'b0);
    check("full_valid", core_valid_o, 4'b0001);
    commit();
    set_in(4'b0100, 1, 0);
    settle_check();
    check("full_gnt", core_gnt_o, 4'b0100);
    commit();
    drain();

    // Spurious valid.
    set_in('0, 0, 1);
    settle_check();
    check("spur_valid", core_valid_o, '0);
    commit();
    set_in('0, 0, 0);
    settle_check();
    check("spur_err", err_o, 1'b1);
    commit();

    // Reset with an operation outstanding.
    do_reset();
    cyc(4'b0001, 1, 0);
    do_reset();
    set_in('0, 0, 1);
    settle_check();
    check("rst_mid_valid", core_valid_o, '0);
    commit();
    set_in('0, 0, 0);
    settle_check();
    check("rst_mid_err", err_o, 1'b1);
    commit();

    // Randomized traffic with occasional protocol violations and resets.
    do_reset();
    req_v    = '0;
    last_gnt = '0;
    for (int t = 0; t < 4000; t++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        req_v    = '0;
        last_gnt = '0;
      end
      for (int c = 0; c < N; c++) begin
        if (req_v[c] && (last_gnt[c] || $urandom_range(0, 49) == 0)) req_v[c] = 1'b0;
        if (!req_v[c] && $urandom_range(0, 9) < 4) req_v[c] = 1'b1;
      end
      cyc(req_v, $urandom_range(0, 9) < 6,
          (m_q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/apu_cluster_arbiter.md
Name: apu_cluster_arbiter

Overview:
- Shares one APU (FPU/DSP unit) between NUM_CORES cv32e40p cores using the core-side APU req/gnt/valid protocol.
- Round-robin arbitration on the request channel; once a request is offered to the APU, the selected core is held until the APU grants it.
- An in-order tag FIFO routes each APU result back to the core that issued it.
- Sits in the cluster between the cores' apu_master_* ports and the shared APU's slave port.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- DEPTH, 2, maximum outstanding APU operations (tag FIFO depth, 1..4).
- APU_NARGS, 3, operands per request.
- APU_WOP, 6, opcode width.
- WAPUTYPE, 6, type field width.
- APU_NDSFLAGS, 15, downstream flag width.
- APU_NUSFLAGS, 5, upstream flag width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- core_req_i  in  NUM_CORES  per-core request.
- core_gnt_o  out  NUM_CORES  per-core grant (one-hot or zero).
- core_operands_i  in  NUM_CORES*APU_NARGS*32  operands; core k occupies slice k.
- core_op_i  in  NUM_CORES*APU_WOP  opcodes.
- core_type_i  in  NUM_CORES*WAPUTYPE  types.
- core_flags_i  in  NUM_CORES*APU_NDSFLAGS  downstream flags.
- core_valid_o  out  NUM_CORES  per-core result valid (one-hot or zero).
- core_result_o  out  32  result, broadcast to all cores.
- core_flags_o  out  APU_NUSFLAGS  upstream flags, broadcast to all cores.
- apu_req_o  out  1  request to APU.
- apu_gnt_i  in  1  APU grant.
- apu_operands_o  out  APU_NARGS*32  selected core's operands.
- apu_op_o  out  APU_WOP  selected core's opcode.
- apu_type_o  out  WAPUTYPE  selected core's type.
- apu_flags_o  out  APU_NDSFLAGS  selected core's flags.
- apu_valid_i  in  1  APU result valid.
- apu_result_i  in  32  APU result.
- apu_flags_i  in  APU_NUSFLAGS  APU upstream flags.
- err_o  out  1  sticky error: apu_valid_i received with no outstanding operation.

Behaviour:
- **Reset values:**
  - state FREE, rr pointer 0, FIFO empty, err_o 0.
  - core_gnt_o and core_valid_o are 0.
  - apu_req_o is 0 unless requests are present after reset deasserts.
- **States:**
  - FREE: winner = first k with core_req_i[k] set, searching from rr pointer upward and wrapping modulo NUM_CORES.
  - LOCKED: winner = the held index `sel_q`.
- **Request path (combinational):**
  - apu_req_o = core_req_i[winner] && count<DEPTH.
  - apu_operands_o, apu_op_o, apu_type_o and apu_flags_o are muxed from winner.
  - When apu_req_o=0, these data outputs carry core 0's fields; their value is don't-care.
- **Grant:**
  - core_gnt_o[winner] = apu_req_o && apu_gnt_i, in the same cycle; the grant is zero-latency pass-through.
  - On grant: push winner into the FIFO, set rr pointer to (winner+1) mod NUM_CORES, and go to FREE.
- **Lock:**
  - In FREE with apu_req_o=1 and apu_gnt_i=0: sel_q<=winner and go to LOCKED.
  - In LOCKED, new higher-priority requests do not change the selection.
  - If core_req_i[sel_q] drops without a grant (a protocol violation), go to FREE on the next cycle with the rr pointer unchanged.
- **FIFO full (count==DEPTH):**
  - apu_req_o=0 and no grant is given, even if a pop happens in the same cycle.
  - State and sel_q are held.
- **Response path (combinational):**
  - When apu_valid_i=1 and the FIFO is non-empty: core_valid_o[head]=1, pop the head.
  - core_result_o=apu_result_i and core_flags_o=apu_flags_i at all times.
  - The APU returns results strictly in issue order; out-of-order APUs are not supported.
- **Simultaneous push and pop** with count<DEPTH: count is unchanged and FIFO order is preserved.
- **Spurious valid:** apu_valid_i=1 with an empty FIFO gives no core_valid_o, and err_o<=1. err_o clears only on reset.
- **Reset mid-operation:**
  - The FIFO is flushed and outstanding tags are lost.
  - Later APU results arriving with an empty FIFO set err_o.
- **Widths and pointers:**
  - The rr pointer is $clog2(NUM_CORES) bits and wraps at NUM_CORES (non-power-of-2 is supported).
  - FIFO pointers are $clog2(DEPTH) bits; count is $clog2(DEPTH+1) bits.

Test Plan:
- **Single core:** core 2 req with op=0x05, apu_gnt_i=1 → same cycle: core_gnt_o=4'b0100 and apu_op_o=0x05. Three cycles later apu_valid_i=1 with result 0xDEADBEEF → core_valid_o=4'b0100 and core_result_o=0xDEADBEEF.
- **Round robin:** cores 0,1,3 hold req continuously with apu_gnt_i=1 → grants in order 0,1,3,0,1 across five cycles.
- **Lock under backpressure:**
  - Core 1 req, apu_gnt_i=0 for 3 cycles, then core 0 also asserts req.
  - → apu_operands_o stays core 1's throughout.
  - When apu_gnt_i=1: core_gnt_o=4'b0010; core 0 is granted on the next grant cycle.
- **FIFO full, DEPTH=2:**
  - Two grants, no valids → third request gets apu_req_o=0.
  - apu_valid_i pulse → core_valid_o goes to the first issuer.
  - Next cycle the third request is granted.
- **Spurious valid:** apu_valid_i=1 with an empty FIFO → core_valid_o=0 and err_o=1, held until rst_i.
- **Reset mid-operation:** one op outstanding, pulse rst_i → all outputs at reset values. A subsequent apu_valid_i gives core_valid_o=0 and err_o=1.
